river_crossing_engine: RTL and testbench
========================================

# river_crossing_engine

Parametrised game engine for the river-crossing puzzle: N passengers, a canoe of configurable capacity, a programmable "cannot be left alone" conflict matrix and per-difficulty move limits. It replaces the fixed three-animal game core and sits between the debounced button/switch front end and the display drivers, which read passenger positions, boat progress, move count and game state. Optional undo replays the last crossings in reverse.

## Interface
- N_PASS, 3: number of passengers; bit 0 = cat, bit 1 = dog, bit 2 = mouse in the default game.
- CAP, 1: maximum passengers per trip.
- STEPS, 4: boat cells from bank to bank, cell 0 = left bank, cell STEPS-1 = right bank.
- TICKS_PER_STEP, 4: clock cycles per boat cell.
- CONFLICT, 9'h006: N_PASS*N_PASS flat matrix; bit i*N_PASS+j set means i and j may not share a bank without the canoe. Either orientation marks a pair.
- LIMIT0..LIMIT3, 15/13/9/7: move limit per difficulty, decimal, 1..99.
- HIST_DEPTH, 8: undo stack depth.
- clk_4Hz  in  1  game clock, all logic on rising edge.
- btn_0_out  in  1  reset, synchronous, active-high.
- play_en  in  1  new requests accepted only when high.
- difficulty  in  2  sampled only in reset cycles.
- req_valid  in  1  crossing request.
- req_mask  in  N_PASS  passengers to carry; all-zero = canoe alone.
- req_ready  out  1  high in IDLE with play_en=1 and game_state=2.
- req_err  out  1  one-cycle pulse on a rejected request.
- undo_req  in  1  undo request.
- pos  out  N_PASS  passenger bank, 0 = left, 1 = right.
- canoe_pos  out  1  canoe bank.
- moving  out  N_PASS  passengers currently aboard.
- boat_cell  out  $clog2(STEPS)  boat cell.
- ones, tens  out  4 each  BCD move count.
- game_state  out  2  0 = lose, 1 = win, 2 = playing.

## Operation
- Reset: pos=0, canoe_pos=0, moving=0, boat_cell=0, ones=tens=0, game_state=2, req_err=0, stack empty, state IDLE, difficulty latched. Reset overrides everything, including mid-crossing.
- States are IDLE, CROSS, CHECK, DONE.
- In IDLE, req_valid&&req_ready either accepts or rejects the request.
  - Accept when every set bit of req_mask has pos equal to canoe_pos and popcount(req_mask) ≤ CAP. Then moving=req_mask and the state goes to CROSS.
  - Otherwise pulse req_err for one cycle and change nothing.
- In CROSS, boat_cell steps one cell toward the far bank every TICKS_PER_STEP cycles.
- Arrival happens on the edge boat_cell reaches the far bank. On that edge:
  - pos[moving] and canoe_pos toggle and moving clears.
  - The BCD move count increments and saturates at 99; an undo decrements it instead.
  - A forward move pushes its mask onto the stack.
  - The state goes to CHECK.
- CHECK takes one cycle and applies the first matching rule, in priority order:
  - all pos=1 → game_state=1, DONE;
  - any conflicting pair i,j with pos[i]==pos[j]!=canoe_pos → game_state=0, DONE;
  - move count == LIMIT[difficulty] → game_state=0, DONE;
  - else IDLE.
- DONE holds every output until reset; all requests are ignored.
- play_en low does not abort a crossing in progress.

## Timing
- Request accepted at edge k: moving and req_ready change at k.
- boat_cell changes at k+T, k+2T, …, where T = TICKS_PER_STEP.
- Arrival at k+(STEPS-1)·T; game_state is updated at arrival+1. With defaults, arrival is at k+12.
- req_ready returns no earlier than arrival+1.
- req_err is asserted the cycle after the rejected request.
- Simultaneous undo_req and req_valid: undo wins and the request is dropped without req_err.

## Configuration
- RIVER_UNDO_EN defined:
  - An undo_req in IDLE with game_state=2 and a non-empty stack pops the top mask and performs its crossing.
  - The undo ignores play_en and CAP, and decrements the move count on arrival.
  - If the stack is full, a push discards the oldest entry.
  - An undo with an empty stack is ignored, with no req_err.
- RIVER_UNDO_EN undefined: undo_req is ignored, no stack is built, and all other behaviour is identical.

## Test plan
- Reset, req_mask=001 → boat_cell 1/2/3 at k+4/8/12; pos=001, canoe_pos=1, ones=1, game_state=2 at k+13.
- Reset, req_mask=010 → at arrival+1, game_state=0 (cat and mouse left without the canoe).
- After cat crosses, req_mask=100 (mouse on the left, canoe on the right) → req_err pulse, no state change. With CAP=1, req_mask=011 → req_err.
- difficulty=3, seven-move solution (cat, back, dog, cat back, mouse, back, cat) → ones=7, game_state=1: win beats limit.
- difficulty=3: cat over, then canoe alone ×6 → game_state=0 at moves=07. Assert btn_0_out at cycle 6 of a crossing → all reset values on the next edge.
- RIVER_UNDO_EN: cat over, then undo_req → pos=000, canoe_pos=0, moves=00; a second undo_req is ignored.

Source files
------------

// File: rtl/river_crossing_engine_if.sv
// Request/undo handshake between the button front end and the river-crossing engine.
// The front end drives the master side; the engine is the slave.
interface river_crossing_engine_if #(
  parameter int N_PASS = 3
) ();
  logic              req_valid;
  logic [N_PASS-1:0] req_mask;
  logic              req_ready;
  logic              req_err;
  logic              undo_req;

  modport master (output req_valid, req_mask, undo_req, input req_ready, req_err);
  modport slave  (input req_valid, req_mask, undo_req, output req_ready, req_err);
endinterface

// File: rtl/river_crossing_engine.sv
// Parametrised river-crossing puzzle engine: canoe crossings, conflict/limit judging, BCD move count.
// Define RIVER_UNDO_EN to build the undo stack that replays past crossings in reverse.
module river_crossing_engine #(
  parameter int                        N_PASS         = 3,
  parameter int                        CAP            = 1,
  parameter int                        STEPS          = 4,
  parameter int                        TICKS_PER_STEP = 4,
  parameter logic [N_PASS*N_PASS-1:0]  CONFLICT       = 9'h006,
  parameter int                        LIMIT0         = 15,
  parameter int                        LIMIT1         = 13,
  parameter int                        LIMIT2         = 9,
  parameter int                        LIMIT3         = 7,
  parameter int                        HIST_DEPTH     = 8
) (
  input  logic                     clk_4Hz,
  input  logic                     btn_0_out,
  input  logic                     play_en,
  input  logic [1:0]               difficulty,
  river_crossing_engine_if.slave   req,
  output logic [N_PASS-1:0]        pos,
  output logic                     canoe_pos,
  output logic [N_PASS-1:0]        moving,
  output logic [$clog2(STEPS)-1:0] boat_cell,
  output logic [3:0]               ones,
  output logic [3:0]               tens,
  output logic [1:0]               game_state
);
  localparam int CW = $clog2(STEPS);
  localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

  typedef enum logic [1:0] {IDLE, CROSS, CHECK, DONE} state_t;

  state_t            state_q;
  logic [N_PASS-1:0] pos_q, moving_q;
  logic              canoe_q, undo_q, err_q;
  logic [CW-1:0]     cell_q;
  logic [TW-1:0]     tick_q;
  logic [3:0]        ones_q, tens_q, ones_d, tens_d;
  logic [1:0]        gstate_q, diff_q;

  logic              req_ready_d, legal_d, step_d, arrive_d;
  logic              undo_fire_d, conflict_d, at_limit_d;
  logic [N_PASS-1:0] pop_mask_d;
  logic [CW-1:0]     cell_next_d, far_d;
  logic [6:0]        moves_bin_d, limit_d;
  logic [N_PASS*N_PASS-1:0] clash_d;

  assign req_ready_d = (state_q == IDLE) && play_en && (gstate_q == 2'd2);
  // Every carried passenger must stand on the canoe's bank.
  assign legal_d     = ((req.req_mask & (pos_q ^ {N_PASS{canoe_q}})) == '0)
                       && ($countones(req.req_mask) <= CAP);
  assign step_d      = (tick_q == TW'(TICKS_PER_STEP - 1));
  assign cell_next_d = canoe_q ? (cell_q - CW'(1)) : (cell_q + CW'(1));
  assign far_d       = canoe_q ? '0 : CW'(STEPS - 1);
  assign arrive_d    = (state_q == CROSS) && step_d && (cell_next_d == far_d);

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_PASS; gi++) begin : g_row
      for (gj = 0; gj < N_PASS; gj++) begin : g_col
        if (gi != gj && (CONFLICT[gi*N_PASS+gj] || CONFLICT[gj*N_PASS+gi])) begin : g_pair
          assign clash_d[gi*N_PASS+gj] = (pos_q[gi] == pos_q[gj]) && (pos_q[gi] != canoe_q);
        end else begin : g_none
          assign clash_d[gi*N_PASS+gj] = 1'b0;
        end
      end
    end
  endgenerate
  assign conflict_d = |clash_d;

  assign moves_bin_d = 7'(tens_q) * 7'd10 + 7'(ones_q);
  always_comb begin
    case (diff_q)
      2'd0:    limit_d = 7'(LIMIT0);
      2'd1:    limit_d = 7'(LIMIT1);
      2'd2:    limit_d = 7'(LIMIT2);
      default: limit_d = 7'(LIMIT3);
    endcase
  end
  assign at_limit_d = (moves_bin_d == limit_d);

  // BCD count: saturates at 99 going up, floors at 00 going down.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (undo_q) begin
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else if (tens_q != 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end
    end else if (!(ones_q == 4'd9 && tens_q == 4'd9)) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

`ifdef RIVER_UNDO_EN
  localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  // Circular stack: a push onto a full stack silently overwrites the oldest entry.
  logic [N_PASS-1:0] hist_mem [HIST_DEPTH];
  logic [HW-1:0]     top_q, top_prev_d, top_next_d;
  logic [HW:0]       depth_q;

  assign top_prev_d  = (top_q == '0) ? HW'(HIST_DEPTH - 1) : (top_q - HW'(1));
  assign top_next_d  = (top_q == HW'(HIST_DEPTH - 1)) ? '0 : (top_q + HW'(1));
  assign undo_fire_d = (state_q == IDLE) && (gstate_q == 2'd2) && req.undo_req && (depth_q != '0);
  assign pop_mask_d  = hist_mem[top_prev_d];

  always_ff @(posedge clk_4Hz) begin
    if (!btn_0_out && arrive_d && !undo_q) begin
      hist_mem[top_q] <= moving_q;
    end
  end

  always_ff @(posedge clk_4Hz) begin
    if (btn_0_out) begin
      top_q   <= '0;
      depth_q <= '0;
    end else if (undo_fire_d) begin
      top_q   <= top_prev_d;
      depth_q <= depth_q - (HW+1)'(1);
    end else if (arrive_d && !undo_q) begin
      top_q <= top_next_d;
      if (depth_q != (HW+1)'(HIST_DEPTH)) begin
        depth_q <= depth_q + (HW+1)'(1);
      end
    end
  end
`else
  assign undo_fire_d = 1'b0;
  assign pop_mask_d  = '0;
  wire unused_undo = &{1'b0, req.undo_req, HIST_DEPTH[0]};
`endif

  always_ff @(posedge clk_4Hz) begin
    if (btn_0_out) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      canoe_q  <= 1'b0;
      moving_q <= '0;
      cell_q   <= '0;
      tick_q   <= '0;
      ones_q   <= 4'd0;
      tens_q   <= 4'd0;
      gstate_q <= 2'd2;
      err_q    <= 1'b0;
      undo_q   <= 1'b0;
      diff_q   <= difficulty;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tick_q <= '0;
          if (undo_fire_d) begin
            moving_q <= pop_mask_d;
            undo_q   <= 1'b1;
            state_q  <= CROSS;
          end else if (req.req_valid && req_ready_d) begin
            if (legal_d) begin
              moving_q <= req.req_mask;
              undo_q   <= 1'b0;
              state_q  <= CROSS;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CROSS: begin
          if (step_d) begin
            tick_q <= '0;
            cell_q <= cell_next_d;
            if (arrive_d) begin
              pos_q    <= pos_q ^ moving_q;
              canoe_q  <= ~canoe_q;
              moving_q <= '0;
              ones_q   <= ones_d;
              tens_q   <= tens_d;
              state_q  <= CHECK;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        CHECK: begin
          if (&pos_q) begin
            gstate_q <= 2'd1;
            state_q  <= DONE;
          end else if (conflict_d || at_limit_d) begin
            gstate_q <= 2'd0;
            state_q  <= DONE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign req.req_ready = req_ready_d;
  assign req.req_err   = err_q;
  assign pos           = pos_q;
  assign canoe_pos     = canoe_q;
  assign moving        = moving_q;
  assign boat_cell     = cell_q;
  assign ones          = ones_q;
  assign tens          = tens_q;
  assign game_state    = gstate_q;
endmodule

// File: tb/tb_river_crossing_engine.sv
// Randomised bench for river_crossing_engine against a bank/stack model of the puzzle rules.
module tb_river_crossing_engine;
  localparam int N = 3;
  localparam int CAP = 1;
  localparam int STEPS = 4;
  localparam int T = 4;
  localparam int HIST_DEPTH = 8;
  localparam logic [8:0] CONFLICT = 9'h006;

  logic         clk_4Hz = 1'b0;
  logic         btn_0_out = 1'b0;
  logic         play_en = 1'b1;
  logic [1:0]   difficulty = 2'd0;
  logic [N-1:0] pos, moving;
  logic         canoe_pos;
  logic [1:0]   boat_cell;
  logic [3:0]   ones, tens;
  logic [1:0]   game_state;

  river_crossing_engine_if #(.N_PASS(N)) bus ();

  river_crossing_engine #(
    .N_PASS(N), .CAP(CAP), .STEPS(STEPS), .TICKS_PER_STEP(T), .CONFLICT(CONFLICT),
    .LIMIT0(15), .LIMIT1(13), .LIMIT2(9), .LIMIT3(7), .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .clk_4Hz(clk_4Hz), .btn_0_out(btn_0_out), .play_en(play_en), .difficulty(difficulty),
    .req(bus), .pos(pos), .canoe_pos(canoe_pos), .moving(moving), .boat_cell(boat_cell),
    .ones(ones), .tens(tens), .game_state(game_state)
  );

  always #5 clk_4Hz = ~clk_4Hz;

  int n_checks = 0;
  int n_pass = 0;

  logic [N-1:0] m_pos;
  logic         m_canoe;
  int           m_moves, m_state, m_diff;
  logic [N-1:0] m_stack[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int lim(input int d);
    case (d)
      0: return 15;
      1: return 13;
      2: return 9;
      default: return 7;
    endcase
  endfunction

  // Game verdict after a crossing: win first, then an unattended conflict, then the move limit.
  function automatic int judge();
    if (m_pos == '1) return 1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i != j && (CONFLICT[i*N+j] || CONFLICT[j*N+i]) &&
            m_pos[i] == m_pos[j] && m_pos[i] != m_canoe) return 0;
    if (m_moves == lim(m_diff)) return 0;
    return 2;
  endfunction

  task automatic check_reset();
    check_val("rst_pos", pos, 0);
    check_val("rst_canoe", canoe_pos, 0);
    check_val("rst_moving", moving, 0);
    check_val("rst_cell", boat_cell, 0);
    check_val("rst_ones", ones, 0);
    check_val("rst_tens", tens, 0);
    check_val("rst_state", game_state, 2);
    check_val("rst_err", bus.req_err, 0);
  endtask

  task automatic do_reset(input int d);
    @(negedge clk_4Hz);
    btn_0_out = 1'b1;
    difficulty = d[1:0];
    bus.req_valid = 1'b0;
    bus.undo_req = 1'b0;
    play_en = 1'b1;
    @(posedge clk_4Hz); #1;
    m_pos = '0; m_canoe = 1'b0; m_moves = 0; m_state = 2; m_diff = d;
    m_stack.delete();
    check_reset();
    @(negedge clk_4Hz);
    btn_0_out = 1'b0;
    difficulty = 2'($urandom);
    $display("reset difficulty=%0d", d);
  endtask

  task automatic run_txn(input logic [N-1:0] mask, input bit valid, input bit undo, input bit pe);
    bit go, is_undo, reject, wrong;
    int carried, cell0;
    logic [N-1:0] mv;
    go = 0; is_undo = 0; reject = 0; wrong = 0; carried = 0; mv = mask;
    if (m_state == 2) begin
`ifdef RIVER_UNDO_EN
      if (undo && m_stack.size() > 0) begin
        is_undo = 1; go = 1; mv = m_stack.pop_back();
      end
`endif
      if (!is_undo && valid && pe) begin
        for (int i = 0; i < N; i++)
          if (mask[i]) begin
            carried++;
            if (m_pos[i] != m_canoe) wrong = 1;
          end
        if (!wrong && carried <= CAP) go = 1;
        else reject = 1;
      end
    end
    @(negedge clk_4Hz);
    bus.req_valid = valid; bus.req_mask = mask; bus.undo_req = undo; play_en = pe;
    @(posedge clk_4Hz); #1;
    bus.req_valid = 1'b0; bus.undo_req = 1'b0; play_en = 1'b1;
    $display("txn mask=%b valid=%0b undo=%0b play_en=%0b -> %s", mask, valid, undo, pe,
             is_undo ? "undo" : go ? "cross" : reject ? "reject" : "ignored");
    if (go) begin
      check_val("moving_on_start", moving, mv);
      check_val("ready_drop", bus.req_ready, 0);
      cell0 = m_canoe ? STEPS - 1 : 0;
      for (int s = 1; s < STEPS; s++) begin
        repeat (T - 1) @(posedge clk_4Hz);
        #1 check_val("cell_hold", boat_cell, m_canoe ? cell0 - (s - 1) : s - 1);
        @(posedge clk_4Hz);
        #1 check_val("cell_step", boat_cell, m_canoe ? cell0 - s : s);
      end
      m_pos = m_pos ^ mv;
      m_canoe = ~m_canoe;
      if (is_undo) begin
        m_moves = (m_moves > 0) ? m_moves - 1 : 0;
      end else begin
        m_moves = (m_moves < 99) ? m_moves + 1 : 99;
        m_stack.push_back(mv);
        if (m_stack.size() > HIST_DEPTH) void'(m_stack.pop_front());
      end
      check_val("arr_pos", pos, m_pos);
      check_val("arr_canoe", canoe_pos, m_canoe);
      check_val("arr_moving", moving, 0);
      check_val("arr_ones", ones, m_moves % 10);
      check_val("arr_tens", tens, m_moves / 10);
      check_val("arr_state_unchanged", game_state, 2);
      @(posedge clk_4Hz); #1;
      m_state = judge();
      check_val("verdict", game_state, m_state);
      check_val("ready_return", bus.req_ready, (m_state == 2) ? 1 : 0);
    end else begin
      check_val("idle_moving", moving, 0);
      check_val("req_err", bus.req_err, reject ? 1 : 0);
      check_val("idle_pos", pos, m_pos);
      check_val("idle_canoe", canoe_pos, m_canoe);
      check_val("idle_state", game_state, m_state);
      @(posedge clk_4Hz); #1;
      check_val("err_one_cycle", bus.req_err, 0);
    end
  endtask

  initial begin
    logic [N-1:0] sol [7];
    logic [N-1:0] rmask;
    int r;
    sol = '{3'b001, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b001};
    bus.req_valid = 1'b0; bus.req_mask = '0; bus.undo_req = 1'b0;

    do_reset(0);
    check_val("ready_after_reset", bus.req_ready, 1);
    run_txn(3'b001, 1, 0, 1);
    check_val("cat_over_ones", ones, 1);

    do_reset(0);
    run_txn(3'b010, 1, 0, 1);
    check_val("dog_first_loses", game_state, 0);
    run_txn(3'b001, 1, 0, 1);

    do_reset(0);
    run_txn(3'b001, 1, 0, 1);
    run_txn(3'b100, 1, 0, 1);
    check_val("wrong_bank_pos", pos, 3'b001);
    do_reset(0);
    run_txn(3'b011, 1, 0, 1);

    do_reset(3);
    foreach (sol[i]) run_txn(sol[i], 1, 0, 1);
    check_val("solution_ones", ones, 7);
    check_val("solution_win", game_state, 1);

    do_reset(3);
    run_txn(3'b001, 1, 0, 1);
    repeat (6) run_txn(3'b000, 1, 0, 1);
    check_val("limit_ones", ones, 7);
    check_val("limit_lose", game_state, 0);

    do_reset(1);
    @(negedge clk_4Hz);
    bus.req_valid = 1'b1; bus.req_mask = 3'b001;
    @(posedge clk_4Hz); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk_4Hz);
    do_reset(2);

`ifdef RIVER_UNDO_EN
    do_reset(0);
    run_txn(3'b001, 1, 0, 1);
    run_txn(3'b000, 0, 1, 1);
    check_val("undo_pos", pos, 0);
    check_val("undo_canoe", canoe_pos, 0);
    check_val("undo_ones", ones, 0);
    run_txn(3'b000, 0, 1, 1);
    check_val("undo_empty_moving", moving, 0);
`endif

    do_reset($urandom_range(0, 3));
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      if (r < 2) rmask = 3'b000;
      else if (r < 7) rmask = 3'(1 << $urandom_range(0, 2));
      else rmask = 3'($urandom_range(0, 7));
      if (m_state != 2) begin
        run_txn(rmask, 1, 1'($urandom_range(0, 1)), 1);
        do_reset($urandom_range(0, 3));
      end else begin
        run_txn(rmask, $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 7) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
